// File: rtl/game_pkg.sv
// Shared gameplay encodings used by the flow controller, display and game-object logic.
package game_pkg;

   localparam int unsigned STATUS_W = 2;

   typedef enum logic [STATUS_W-1:0] {
      STATUS_TITLE    = 2'd0,
      STATUS_PLAYING  = 2'd1,
      STATUS_RESPAWN  = 2'd2,
      STATUS_GAMEOVER = 2'd3
   } status_t;

endpackage

// File: rtl/life_flow_controller_if.sv
// Player-control inputs and HUD/engine status outputs of the life flow controller.
interface life_flow_controller_if
   import game_pkg::*;
#(
   parameter int unsigned LIVES_W = 3
);
   logic               frame_tick;
   logic               start_pulse;
   logic               pause_pulse;
   logic               hit_pulse;
   logic               bonus_pulse;
   logic [LIVES_W-1:0] lives;
   status_t            gameplay_status;
   logic               paused;
   logic               invulnerable;
   logic               respawn_pulse;
   logic               hit_ack;

   modport master (
      output frame_tick, start_pulse, pause_pulse, hit_pulse, bonus_pulse,
      input  lives, gameplay_status, paused, invulnerable, respawn_pulse, hit_ack
   );

   modport slave (
      input  frame_tick, start_pulse, pause_pulse, hit_pulse, bonus_pulse,
      output lives, gameplay_status, paused, invulnerable, respawn_pulse, hit_ack
   );
endinterface

// File: rtl/frame_down_timer.sv
// Loadable frame-count down timer that saturates at zero; zero flag is registered with the count.
module frame_down_timer #(
   parameter int unsigned TIMER_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_value_i,
   input  logic               tick_i,
   input  logic               freeze_i,
   output logic [TIMER_W-1:0] count_o,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_d;
   logic [TIMER_W-1:0] count_q;
   logic               zero_q;

   // Load wins over a coincident tick.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_value_i;
      end else if (tick_i && !freeze_i && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= (count_d == '0);
      end
   end

   assign count_o = count_q;
   assign zero_o  = zero_q;

endmodule

// File: rtl/life_flow_controller.sv
// Game flow sequencer: owns lives, respawn delay, spawn invulnerability and pause.
module life_flow_controller
   import game_pkg::*;
#(
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned MAX_LIVES     = 7,
   parameter int unsigned LIVES_W       = 3,
   parameter int unsigned RESPAWN_TICKS = 120,
   parameter int unsigned INVULN_TICKS  = 180,
   parameter int unsigned TIMER_W       = 8
) (
   input logic                   clk,
   input logic                   rst,
   life_flow_controller_if.slave ctrl
);

   status_t            state_d,   state_q;
   logic [LIVES_W-1:0] lives_d,   lives_q;
   logic               paused_d,  paused_q;
   logic               invuln_d,  invuln_q;
   logic               respawn_d, respawn_q;
   logic               hit_ack_d, hit_ack_q;

   logic               resp_load, resp_freeze, resp_zero;
   logic [TIMER_W-1:0] resp_count;
   logic               inv_load,  inv_freeze,  inv_zero, inv_dec, inv_nonzero_d;
   logic [TIMER_W-1:0] inv_count;
   logic [LIVES_W-1:0] lives_inc;
   logic               live;

   assign live        = !paused_q && ((state_q == STATUS_PLAYING) || (state_q == STATUS_RESPAWN));
   assign resp_freeze = paused_q || (state_q != STATUS_RESPAWN);
   assign inv_freeze  = paused_q || (state_q != STATUS_PLAYING);
   assign lives_inc   = (lives_q >= LIVES_W'(MAX_LIVES)) ? LIVES_W'(MAX_LIVES)
                                                         : lives_q + LIVES_W'(1);

   frame_down_timer #(.TIMER_W(TIMER_W)) u_resp_timer (
      .clk          (clk),
      .rst          (rst),
      .load_i       (resp_load),
      .load_value_i (TIMER_W'(RESPAWN_TICKS)),
      .tick_i       (ctrl.frame_tick),
      .freeze_i     (resp_freeze),
      .count_o      (resp_count),
      .zero_o       (resp_zero)
   );

   frame_down_timer #(.TIMER_W(TIMER_W)) u_inv_timer (
      .clk          (clk),
      .rst          (rst),
      .load_i       (inv_load),
      .load_value_i (TIMER_W'(INVULN_TICKS)),
      .tick_i       (ctrl.frame_tick),
      .freeze_i     (inv_freeze),
      .count_o      (inv_count),
      .zero_o       (inv_zero)
   );

   // Next-state, lives and pulse generation.
   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      paused_d  = paused_q;
      respawn_d = 1'b0;
      hit_ack_d = 1'b0;
      resp_load = 1'b0;
      inv_load  = 1'b0;

      unique case (state_q)
         STATUS_TITLE: begin
            if (ctrl.start_pulse) begin
               state_d   = STATUS_PLAYING;
               lives_d   = LIVES_W'(START_LIVES);
               inv_load  = 1'b1;
               respawn_d = 1'b1;
            end
         end
         STATUS_PLAYING: begin
            if (live) begin
               if (ctrl.hit_pulse && inv_zero) begin
                  hit_ack_d = 1'b1;
                  if (lives_q <= LIVES_W'(1)) begin
                     lives_d = '0;
                     state_d = STATUS_GAMEOVER;
                  end else begin
                     lives_d   = lives_q - LIVES_W'(1);
                     state_d   = STATUS_RESPAWN;
                     resp_load = 1'b1;
                  end
               end else if (ctrl.bonus_pulse) begin
                  lives_d = lives_inc;
               end
            end
         end
         STATUS_RESPAWN: begin
            if (live) begin
               if (ctrl.bonus_pulse) begin
                  lives_d = lives_inc;
               end
               // resp_zero guards against ever stalling here with an empty timer.
               if (ctrl.frame_tick && ((resp_count == TIMER_W'(1)) || resp_zero)) begin
                  state_d   = STATUS_PLAYING;
                  respawn_d = 1'b1;
                  inv_load  = 1'b1;
               end
            end
         end
         STATUS_GAMEOVER: begin
            lives_d = '0;
            if (ctrl.start_pulse) begin
               state_d = STATUS_TITLE;
            end
         end
         default: state_d = STATUS_TITLE;
      endcase

      if (ctrl.pause_pulse && ((state_q == STATUS_PLAYING) || (state_q == STATUS_RESPAWN))) begin
         paused_d = !paused_q;
      end
      if ((state_d == STATUS_TITLE) || (state_d == STATUS_GAMEOVER)) begin
         paused_d = 1'b0;
      end
   end

   // Invulnerability flag tracks the timer value it will hold next cycle.
   always_comb begin
      inv_dec = ctrl.frame_tick && !inv_freeze && !inv_zero;
      if (inv_load) begin
         inv_nonzero_d = (INVULN_TICKS != 0);
      end else if (inv_dec) begin
         inv_nonzero_d = (inv_count != TIMER_W'(1));
      end else begin
         inv_nonzero_d = !inv_zero;
      end
      invuln_d = (state_d == STATUS_RESPAWN) || ((state_d == STATUS_PLAYING) && inv_nonzero_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= STATUS_TITLE;
         lives_q   <= LIVES_W'(START_LIVES);
         paused_q  <= 1'b0;
         invuln_q  <= 1'b0;
         respawn_q <= 1'b0;
         hit_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         paused_q  <= paused_d;
         invuln_q  <= invuln_d;
         respawn_q <= respawn_d;
         hit_ack_q <= hit_ack_d;
      end
   end

   assign ctrl.lives           = lives_q;
   assign ctrl.gameplay_status = state_q;
   assign ctrl.paused          = paused_q;
   assign ctrl.invulnerable    = invuln_q;
   assign ctrl.respawn_pulse   = respawn_q;
   assign ctrl.hit_ack         = hit_ack_q;

endmodule

// File: tb/tb_life_flow_controller.sv
// Directed bench for life_flow_controller with a frame-level game model checked every cycle.
module tb_life_flow_controller;
   import game_pkg::*;

   localparam int unsigned START_LIVES   = 3;
   localparam int unsigned MAX_LIVES     = 7;
   localparam int unsigned LIVES_W       = 3;
   localparam int unsigned RESPAWN_TICKS = 120;
   localparam int unsigned INVULN_TICKS  = 180;
   localparam int unsigned TIMER_W       = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   life_flow_controller_if #(.LIVES_W(LIVES_W)) bus ();

   life_flow_controller #(
      .START_LIVES   (START_LIVES),
      .MAX_LIVES     (MAX_LIVES),
      .LIVES_W       (LIVES_W),
      .RESPAWN_TICKS (RESPAWN_TICKS),
      .INVULN_TICKS  (INVULN_TICKS),
      .TIMER_W       (TIMER_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus.slave)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Game model: status 0..3, remaining frames for each timer, pending pulses.
   int m_status, m_lives, m_paused, m_inv_left, m_resp_left, m_respawn, m_hit_ack;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_update();
      int prev;
      bit running;
      prev      = m_status;
      running   = (m_status == 1 || m_status == 2) && (m_paused == 0);
      m_respawn = 0;
      m_hit_ack = 0;
      if (rst) begin
         m_status = 0; m_lives = START_LIVES; m_paused = 0; m_inv_left = 0; m_resp_left = 0;
         return;
      end
      case (m_status)
         0: if (bus.start_pulse) begin
               m_status = 1; m_lives = START_LIVES; m_inv_left = INVULN_TICKS; m_respawn = 1;
            end
         1: if (running) begin
               if (bus.hit_pulse && m_inv_left == 0) begin
                  m_hit_ack = 1;
                  m_lives   = m_lives - 1;
                  if (m_lives == 0) m_status = 3;
                  else begin m_status = 2; m_resp_left = RESPAWN_TICKS; end
               end else begin
                  if (bus.bonus_pulse) m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
                  if (bus.frame_tick && m_inv_left > 0) m_inv_left = m_inv_left - 1;
               end
            end
         2: if (running) begin
               if (bus.bonus_pulse) m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
               if (bus.frame_tick) begin
                  m_resp_left = m_resp_left - 1;
                  if (m_resp_left == 0) begin
                     m_status = 1; m_respawn = 1; m_inv_left = INVULN_TICKS;
                  end
               end
            end
         default: begin
               m_lives = 0;
               if (bus.start_pulse) m_status = 0;
            end
      endcase
      if (bus.pause_pulse && (prev == 1 || prev == 2)) m_paused = 1 - m_paused;
      if (m_status == 0 || m_status == 3) m_paused = 0;
   endtask

   task automatic compare_outputs();
      int exp_inv;
      exp_inv = (m_status == 2 || (m_status == 1 && m_inv_left > 0)) ? 1 : 0;
      check("status",        int'(bus.gameplay_status), m_status);
      check("lives",         int'(bus.lives),           m_lives);
      check("paused",        int'(bus.paused),          m_paused);
      check("invulnerable",  int'(bus.invulnerable),    exp_inv);
      check("respawn_pulse", int'(bus.respawn_pulse),   m_respawn);
      check("hit_ack",       int'(bus.hit_ack),         m_hit_ack);
   endtask

   // One clock: drive inputs, let the DUT and model advance, compare at the falling edge.
   task automatic cyc(input logic f, input logic s, input logic p, input logic h, input logic b);
      bus.frame_tick  = f;
      bus.start_pulse = s;
      bus.pause_pulse = p;
      bus.hit_pulse   = h;
      bus.bonus_pulse = b;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_state(input string name, input int st, input int lv);
      check({name, "_status"}, int'(bus.gameplay_status), st);
      check({name, "_lives"},  int'(bus.lives),           lv);
   endtask

   initial begin
      int cnt;
      m_status = 0; m_lives = START_LIVES; m_paused = 0;
      m_inv_left = 0; m_resp_left = 0; m_respawn = 0; m_hit_ack = 0;

      // Reset values
      rst = 1'b1;
      idle(); idle();
      rst = 1'b0;
      idle();
      chk_state("reset", 0, 3);
      check("reset_paused", int'(bus.paused), 0);
      check("reset_inv",    int'(bus.invulnerable), 0);

      // Start: one respawn pulse, invulnerable for exactly 180 frames
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_state("start", 1, 3);
      check("start_respawn", int'(bus.respawn_pulse), 1);
      check("start_inv",     int'(bus.invulnerable), 1);
      idle();
      check("start_respawn_done", int'(bus.respawn_pulse), 0);
      cnt = 0;
      while (bus.invulnerable && cnt < 400) begin
         frames(1);
         cnt++;
      end
      check("inv_frames", cnt, 180);

      // Accepted hit, ignored hit in RESPAWN, 120-frame delay, ignored hit while invulnerable
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state("hit1", 2, 2);
      check("hit1_ack", int'(bus.hit_ack), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state("hit_in_respawn", 2, 2);
      check("hit_in_respawn_ack", int'(bus.hit_ack), 0);
      frames(119);
      chk_state("respawn_119", 2, 2);
      frames(1);
      chk_state("respawn_120", 1, 2);
      check("respawn_pulse", int'(bus.respawn_pulse), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state("hit_invuln", 1, 2);
      check("hit_invuln_ack", int'(bus.hit_ack), 0);

      // Pause freezes the respawn timer at 50
      frames(179);
      check("inv_over", int'(bus.invulnerable), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state("hit2", 2, 1);
      frames(70);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("pause_on", int'(bus.paused), 1);
      frames(100);
      chk_state("paused_100", 2, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_state("bonus_paused", 2, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("pause_off", int'(bus.paused), 0);
      frames(49);
      chk_state("unpaused_49", 2, 1);
      frames(1);
      chk_state("unpaused_50", 1, 1);

      // Hit with pause from 2 lives, then reset in RESPAWN at 1 life
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_state("bonus_invuln", 1, 2);
      frames(180);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_state("hit_pause", 2, 1);
      check("hit_pause_paused", int'(bus.paused), 1);
      check("hit_pause_ack",    int'(bus.hit_ack), 1);
      frames(3);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk_state("mid_reset", 0, 3);
      check("mid_reset_paused", int'(bus.paused), 0);
      check("mid_reset_inv",    int'(bus.invulnerable), 0);

      // Three hits from 3 lives to GAME_OVER, then back through TITLE
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      frames(180);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frames(120 + 180);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state("go_hit2", 2, 1);
      frames(120 + 180);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state("gameover", 3, 0);
      check("gameover_ack", int'(bus.hit_ack), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_state("gameover_hold", 3, 0);
      check("gameover_paused", int'(bus.paused), 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("title_status", int'(bus.gameplay_status), 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_state("restart", 1, 3);

      // Bonus saturation and hit+bonus in one cycle
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_state("saturate", 1, 7);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_state("start_ignored", 1, 7);
      frames(180);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_state("hit_bonus", 2, 6);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_state("bonus_respawn", 2, 7);
      frames(120);
      chk_state("final", 1, 7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
